// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out register with a bit counter that frames
// WIDTH-bit words and hands each one to a consumer through a valid/ack handshake.
module sipo_deserializer #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pin,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    input  logic             word_ack,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        shifted = dir ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};
    end

    // A load takes priority over shift_en, so a loaded cycle never completes a word.
    assign complete = shift_en && !load && (bit_cnt == LAST_BIT);

    assign sout = dir ? q[WIDTH-1] : q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                q       <= pin;
                bit_cnt <= '0;
            end else if (shift_en) begin
                q       <= shifted;
                bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
            end

            // A fresh word always wins over an ack arriving on the same edge.
            if (complete) begin
                word       <= shifted;
                word_valid <= 1'b1;
                if (word_valid && !word_ack) begin
                    overrun <= 1'b1;
                end
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives WIDTH=4 and WIDTH=8 deserializers with the same stimulus and checks
// both against a word-level model plus the fixed scenarios of the test plan.
module tb_sipo_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        shift_en = 1'b0;
    logic        dir = 1'b0;
    logic        sin = 1'b0;
    logic        word_ack = 1'b0;
    logic [31:0] pin_v = '0;

    logic [3:0] q4, word4;
    logic [2:0] bit_cnt4;
    logic       sout4, word_valid4, overrun4;
    logic [7:0] q8, word8;
    logic [3:0] bit_cnt8;
    logic       sout8, word_valid8, overrun8;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] q;
        int          cnt;
        logic [31:0] word;
        bit          valid;
        bit          ovr;
    } model_t;

    model_t m4, m8;

    sipo_deserializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .pin(pin_v[3:0]), .shift_en(shift_en),
        .dir(dir), .sin(sin), .word_ack(word_ack), .q(q4), .sout(sout4),
        .bit_cnt(bit_cnt4), .word(word4), .word_valid(word_valid4), .overrun(overrun4)
    );

    sipo_deserializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load(load), .pin(pin_v[7:0]), .shift_en(shift_en),
        .dir(dir), .sin(sin), .word_ack(word_ack), .q(q8), .sout(sout8),
        .bit_cnt(bit_cnt8), .word(word8), .word_valid(word_valid8), .overrun(overrun8)
    );

    always #5 clk = ~clk;

    // Word-level reference: the register is an integer shifted arithmetically,
    // and a word is framed whenever the count of accepted bits reaches w.
    function automatic model_t modelStep(model_t m, int w, bit r, bit l, bit se, bit d,
                                         bit s, bit a, logic [31:0] p);
        logic [31:0] mask;
        bit          done;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        done = 1'b0;
        if (r) begin
            m = '{q: 32'd0, cnt: 0, word: 32'd0, valid: 1'b0, ovr: 1'b0};
            return m;
        end
        if (l) begin
            m.q = p & mask;
            m.cnt = 0;
        end else if (se) begin
            if (d) m.q = ((m.q << 1) | 32'(s)) & mask;
            else   m.q = (m.q >> 1) | (32'(s) << (w - 1));
            m.cnt = m.cnt + 1;
            if (m.cnt == w) begin
                m.cnt = 0;
                done = 1'b1;
            end
        end
        if (done) begin
            if (m.valid && !a) m.ovr = 1'b1;
            m.word = m.q;
            m.valid = 1'b1;
        end else if (a) begin
            m.valid = 1'b0;
        end
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("q4", 32'(q4), m4.q);
        checkOutput("bit_cnt4", 32'(bit_cnt4), 32'(m4.cnt));
        checkOutput("word4", 32'(word4), m4.word);
        checkOutput("word_valid4", 32'(word_valid4), 32'(m4.valid));
        checkOutput("overrun4", 32'(overrun4), 32'(m4.ovr));
        checkOutput("sout4", 32'(sout4), 32'(dir ? m4.q[3] : m4.q[0]));
        checkOutput("q8", 32'(q8), m8.q);
        checkOutput("bit_cnt8", 32'(bit_cnt8), 32'(m8.cnt));
        checkOutput("word8", 32'(word8), m8.word);
        checkOutput("word_valid8", 32'(word_valid8), 32'(m8.valid));
        checkOutput("overrun8", 32'(overrun8), 32'(m8.ovr));
        checkOutput("sout8", 32'(sout8), 32'(dir ? m8.q[7] : m8.q[0]));
    endtask

    task automatic applyStimulus(input bit r, input bit l, input bit se, input bit d,
                                 input bit s, input bit a, input logic [31:0] p);
        rst = r; load = l; shift_en = se; dir = d; sin = s; word_ack = a; pin_v = p;
        @(posedge clk);
        #1;
        m4 = modelStep(m4, 4, r, l, se, d, s, a, p);
        m8 = modelStep(m8, 8, r, l, se, d, s, a, p);
        compareAll();
    endtask

    logic [3:0] exp_right [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    logic [3:0] exp_left  [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    bit         bits_a    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit         gap_en    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        m4 = '{q: 32'd0, cnt: 0, word: 32'd0, valid: 1'b0, ovr: 1'b0};
        m8 = m4;
        #2;

        // Legacy right-shift order
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, bits_a[i], 0, 0);
            checkOutput("plan_right_q", 32'(q4), 32'(exp_right[i]));
        end
        checkOutput("plan_right_word", 32'(word4), 32'h0000_000D);
        checkOutput("plan_right_valid", 32'(word_valid4), 32'd1);

        // Left shift
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, bits_a[i], 0, 0);
            checkOutput("plan_left_q", 32'(q4), 32'(exp_left[i]));
        end
        checkOutput("plan_left_word", 32'(word4), 32'h0000_000B);

        // Parallel load beats shift_en, then shift zeros through
        applyStimulus(0, 1, 1, 0, 1, 0, 32'h0000_00A5);
        checkOutput("plan_load_q8", 32'(q8), 32'h0000_00A5);
        checkOutput("plan_load_cnt8", 32'(bit_cnt8), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("plan_load_word8", 32'(word8), 32'd0);

        // Overrun without ack
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("plan_ovr_set", 32'(overrun4), 32'd1);
        checkOutput("plan_ovr_word", 32'(word4), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("plan_ack_clears", 32'(word_valid4), 32'd0);
        checkOutput("plan_ovr_sticky", 32'(overrun4), 32'd1);

        // Ack on the completing edge avoids overrun
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        checkOutput("plan_ack_same_edge_ovr", 32'(overrun4), 32'd0);
        checkOutput("plan_ack_same_edge_valid", 32'(word_valid4), 32'd1);

        // Reset mid-word
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        checkOutput("plan_rst_mid_q", 32'(q4), 32'd0);
        checkOutput("plan_rst_mid_cnt", 32'(bit_cnt4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 0, 0);
            checkOutput("plan_rst_mid_valid", 32'(word_valid4), (i == 3) ? 32'd1 : 32'd0);
        end

        // Gapped input
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, gap_en[i], 0, 1, 0, 0);
            checkOutput("plan_gap_valid", 32'(word_valid4), (i == 6) ? 32'd1 : 32'd0);
        end
        checkOutput("plan_gap_word", 32'(word4), 32'h0000_000F);

        // Randomized traffic
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 3,
                          $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-to-parallel deserializer with a framed word output. It generalises the fixed 4-bit serial-in/parallel-out register to WIDTH bits, selectable shift direction, a parallel load, and a serial output. It also adds a bit counter that emits each completed word through a valid/ack handshake with overrun detection. It sits between a serial bit source (UART/SPI-style receive path) and word-oriented consumer logic.

## Interface
- WIDTH, 8, shift register and word width; legal range 2..32.
- CNT_W, derived localparam = clog2(WIDTH+1), width of bit_cnt; not overridable.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  parallel load of pin into q.
- pin  in  WIDTH  parallel load data.
- shift_en  in  1  accept sin on this edge.
- dir  in  1  0: right shift, sin enters q[WIDTH-1] (legacy order); 1: left shift, sin enters q[0].
- sin  in  1  serial data in.
- word_ack  in  1  consumer takes word this cycle.
- q  out  WIDTH  live shift register contents.
- sout  out  1  bit that would be shifted out next: q[0] when dir=0, q[WIDTH-1] when dir=1; combinational from q and dir.
- bit_cnt  out  CNT_W  bits accepted in current word, 0..WIDTH-1.
- word  out  WIDTH  last completed word, registered.
- word_valid  out  1  word holds an unconsumed word.
- overrun  out  1  sticky: a completed word overwrote an unconsumed word.

## Operation
- Priority per edge: rst > load > shift_en. Counter, handshake, and overrun logic are evaluated in the same edge.
- rst: q=0, bit_cnt=0, word=0, word_valid=0, overrun=0. Applies mid-word and discards the partial word.
- load (no rst): q=pin, bit_cnt=0, sin ignored. word, word_valid, and overrun are untouched; word_ack is still honoured.
- shift_en (no rst, no load):
  - dir=0: q <= {sin, q[WIDTH-1:1]}.
  - dir=1: q <= {q[WIDTH-2:0], sin}.
  - bit_cnt increments.
- Word completion: a shift with bit_cnt==WIDTH-1 is the completing shift.
  - bit_cnt wraps to 0.
  - word <= new q value, including the completing bit.
  - word_valid <= 1.
- Handshake:
  - word_ack with word_valid=1 and no completion clears word_valid.
  - word_ack with word_valid=0 is ignored.
  - Completion plus word_ack in the same edge: word is replaced, word_valid stays 1, overrun is unchanged.
- Overrun: completion while word_valid=1 and word_ack=0 sets overrun=1 and overwrites word with the newest value. Only rst clears overrun.
- dir may change between shifts mid-word. bit_cnt still counts accepted bits and no error is flagged.
- shift_en=0 and load=0: q and bit_cnt hold.

## Timing
- All state updates on the rising edge of clk; no combinational path from sin to q, word, or word_valid.
- q reflects the accepted bit 1 cycle after the shift_en edge.
- word and word_valid update on the completing edge itself. word_valid is visible the cycle after the WIDTH-th shift_en cycle, i.e. latency = 1 clk from the last bit.
- Back-to-back words at one bit per clock are sustained with no bubble. The consumer has WIDTH cycles to ack before an overrun.
- word_ack is sampled on the edge. word_valid falls the cycle after the ack cycle.
- sout changes combinationally with dir and q and has no reset value of its own beyond q=0 → sout=0.

## Test plan
- Reset then legacy order, WIDTH=4, dir=0:
  - Stimulus: shift sin 1,0,1,1 on consecutive clocks.
  - Response: q = 1000, 0100, 1010, 1101; bit_cnt = 1,2,3,0; word=1101 and word_valid=1 after the 4th edge.
- Left shift, WIDTH=4, dir=1:
  - Stimulus: same bits 1,0,1,1.
  - Response: q = 0001, 0010, 0101, 1011; word=1011; sout = q[3] each cycle.
- Parallel load:
  - Stimulus: load pin=8'hA5 with shift_en=1 in the same cycle, WIDTH=8.
  - Response: q=A5 and bit_cnt=0; word/word_valid unchanged.
  - Then 8 dir=0 shifts of 0: q=00 and word=00.
- Handshake and overrun, WIDTH=4:
  - Stimulus: complete word 1111 without ack, then complete 0000 without ack.
  - Response: overrun=1 and word=0000; ack clears word_valid next cycle and overrun stays 1.
  - Repeat from reset with ack on the completing edge: overrun=0.
- Reset mid-word:
  - Stimulus: after 2 shifts, assert rst with shift_en=1.
  - Response: q=0 and bit_cnt=0; the next 4 shifts produce exactly one word with no early word_valid.
- Gapped input:
  - Stimulus: shift_en toggled 1,0,0,1,1,0,1 with sin=1 throughout, WIDTH=4.
  - Response: q and bit_cnt hold on 0-cycles; word_valid rises only after the 4th accepted bit; word=1111.
